// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer slice: word width, default depth
// and the byte-offset field that marks a word-aligned address.
package store_buffer_pkg;

    localparam int WORD_W   = 32;
    localparam int SB_DEPTH = 4;
    localparam int OFFSET_W = 2;

    function automatic logic offset_nonzero(input logic [OFFSET_W-1:0] offset);
        return offset != '0;
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// CPU-side store/load lookup signals plus the data-memory write port of the store buffer.
interface store_buffer_if
    import store_buffer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = WORD_W
);

    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_hit;
    logic [DATA_W-1:0] ld_data;
    logic              mem_port_busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              _WR;
    logic              empty;
    logic              misalign;

    modport master (
        output st_valid, st_addr, st_data, ld_req, ld_addr, mem_port_busy,
        input  st_ready, ld_hit, ld_data, mem_addr, mem_wdata, _WR, empty, misalign
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_req, ld_addr, mem_port_busy,
        output st_ready, ld_hit, ld_data, mem_addr, mem_wdata, _WR, empty, misalign
    );

endinterface

// File: rtl/sb_forward_match.sv
// Combinational store-to-load forwarding: youngest matching buffered entry wins,
// then older entries, then the word currently being written to memory.
module sb_forward_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH       = SB_DEPTH,
    parameter int WORD_ADDR_W = 30,
    parameter int DATA_W      = WORD_W,
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic                   ld_req,
    input  logic [WORD_ADDR_W-1:0] ld_word,
    input  logic [WORD_ADDR_W-1:0] entry_word [DEPTH],
    input  logic [DATA_W-1:0]      entry_data [DEPTH],
    input  logic [DEPTH-1:0]       entry_valid,
    input  logic [PTR_W-1:0]       head,
    input  logic                   inflight_valid,
    input  logic [WORD_ADDR_W-1:0] inflight_word,
    input  logic [DATA_W-1:0]      inflight_data,
    output logic                   hit,
    output logic [DATA_W-1:0]      data
);

    // Walk from oldest (head) to youngest so a later match overrides an earlier one.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hit  = 1'b0;
        data = '0;
        idx  = head;
        if (ld_req) begin
            if (inflight_valid && (inflight_word == ld_word)) begin
                hit  = 1'b1;
                data = inflight_data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = head + PTR_W'(i);
                if (entry_valid[idx] && (entry_word[idx] == ld_word)) begin
                    hit  = 1'b1;
                    data = entry_data[idx];
                end
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Write buffer between the execute stage and data memory: single-cycle store enqueue,
// one-word-per-cycle drain when the memory port is free, and store-to-load forwarding.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = 32,
    parameter int DATA_W = WORD_W
) (
    input logic           clock,
    input logic           reset,
    store_buffer_if.slave bus
);

    localparam int PTR_W       = $clog2(DEPTH);
    localparam int COUNT_W     = PTR_W + 1;
    localparam int WORD_ADDR_W = ADDR_W - OFFSET_W;

    logic [ADDR_W-1:0]      entry_addr [DEPTH];
    logic [DATA_W-1:0]      entry_data [DEPTH];
    logic [WORD_ADDR_W-1:0] entry_word [DEPTH];
    logic [DEPTH-1:0]       entry_valid;

    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] count_next;
    logic               push;
    logic               drain;
    logic               misalign_seen;

    logic              st_ready_q;
    logic              wr_n_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              misalign_q;

    always_comb begin
        push  = bus.st_valid && st_ready_q;
        drain = (count != '0) && !bus.mem_port_busy;
        misalign_seen = (bus.st_valid && offset_nonzero(bus.st_addr[OFFSET_W-1:0]))
                     || (bus.ld_req   && offset_nonzero(bus.ld_addr[OFFSET_W-1:0]));
    end

    always_comb begin
        count_next = count;
        if (push && !drain) begin
            count_next = count + 1'b1;
        end else if (!push && drain) begin
            count_next = count - 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_word[i] = entry_addr[i][ADDR_W-1:OFFSET_W];
        end
    end

    // Payload storage needs no reset; entry_valid alone decides what is live.
    always_ff @(posedge clock) begin
        if (push) begin
            entry_addr[tail] <= bus.st_addr;
            entry_data[tail] <= bus.st_data;
        end
    end

    // st_ready follows the post-edge count so a full buffer reopens one cycle after a drain.
    always_ff @(posedge clock) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            entry_valid <= '0;
            st_ready_q  <= 1'b1;
            wr_n_q      <= 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            if (push) begin
                entry_valid[tail] <= 1'b1;
                tail              <= tail + 1'b1;
            end
            if (drain) begin
                mem_addr_q        <= entry_addr[head];
                mem_wdata_q       <= entry_data[head];
                entry_valid[head] <= 1'b0;
                head              <= head + 1'b1;
            end
            wr_n_q     <= !drain;
            count      <= count_next;
            st_ready_q <= (count_next != COUNT_W'(DEPTH));
            if (misalign_seen) begin
                misalign_q <= 1'b1;
            end
        end
    end

    sb_forward_match #(
        .DEPTH       (DEPTH),
        .WORD_ADDR_W (WORD_ADDR_W),
        .DATA_W      (DATA_W)
    ) u_forward (
        .ld_req         (bus.ld_req),
        .ld_word        (bus.ld_addr[ADDR_W-1:OFFSET_W]),
        .entry_word     (entry_word),
        .entry_data     (entry_data),
        .entry_valid    (entry_valid),
        .head           (head),
        .inflight_valid (!wr_n_q),
        .inflight_word  (mem_addr_q[ADDR_W-1:OFFSET_W]),
        .inflight_data  (mem_wdata_q),
        .hit            (bus.ld_hit),
        .data           (bus.ld_data)
    );

    assign bus.st_ready  = st_ready_q;
    assign bus._WR       = wr_n_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.empty     = (count == '0) && wr_n_q;
    assign bus.misalign  = misalign_q;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: directed scenarios plus random traffic checked
// against a queue-based model of buffered stores, the in-flight write and forwarding.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = SB_DEPTH;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } word_t;

    typedef struct {
        logic        hit;
        logic [31:0] data;
    } load_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    store_buffer_if sb_if ();

    store_buffer dut (
        .clock (clock),
        .reset (reset),
        .bus   (sb_if)
    );

    always #5 clock = ~clock;

    int n_compared   = 0;
    int n_mismatched = 0;
    bit checking     = 1'b0;

    word_t       model_pending [$];
    word_t       model_inflight;
    bit          model_inflight_v = 1'b0;
    logic [31:0] model_mem_addr   = '0;
    logic [31:0] model_mem_wdata  = '0;
    bit          model_misalign   = 1'b0;

    word_t       wr_q [$];
    load_t       ld_q [$];
    logic [31:0] tb_mem [logic [31:0]];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Youngest buffered store to the same word wins, then the word being written.
    function automatic load_t model_load(input logic [31:0] a);
        load_t r;
        r.hit  = 1'b0;
        r.data = '0;
        for (int i = model_pending.size() - 1; i >= 0; i--) begin
            if (model_pending[i].addr[31:2] == a[31:2]) begin
                r.hit  = 1'b1;
                r.data = model_pending[i].data;
                break;
            end
        end
        if (!r.hit && model_inflight_v && (model_inflight.addr[31:2] == a[31:2])) begin
            r.hit  = 1'b1;
            r.data = model_inflight.data;
        end
        return r;
    endfunction

    task automatic model_edge();
        bit    can_push;
        word_t w;
        can_push = (model_pending.size() < DEPTH);
        if (reset) begin
            model_pending.delete();
            wr_q.delete();
            model_inflight_v = 1'b0;
            model_mem_addr   = '0;
            model_mem_wdata  = '0;
            model_misalign   = 1'b0;
        end else begin
            if ((sb_if.st_valid && sb_if.st_addr[1:0] != 2'b00) ||
                (sb_if.ld_req && sb_if.ld_addr[1:0] != 2'b00))
                model_misalign = 1'b1;
            if (model_pending.size() > 0 && !sb_if.mem_port_busy) begin
                model_inflight   = model_pending.pop_front();
                model_inflight_v = 1'b1;
                model_mem_addr   = model_inflight.addr;
                model_mem_wdata  = model_inflight.data;
            end else begin
                model_inflight_v = 1'b0;
            end
            if (sb_if.st_valid && can_push) begin
                w.addr = sb_if.st_addr;
                w.data = sb_if.st_data;
                model_pending.push_back(w);
                wr_q.push_back(w);
            end
        end
    endtask

    task automatic drive_inputs(input bit st_v, input logic [31:0] st_a, input logic [31:0] st_d,
                                input bit ld_r, input logic [31:0] ld_a, input bit busy, input bit rst);
        reset               = rst;
        sb_if.st_valid      = st_v;
        sb_if.st_addr       = st_a;
        sb_if.st_data       = st_d;
        sb_if.ld_req        = ld_r;
        sb_if.ld_addr       = ld_a;
        sb_if.mem_port_busy = busy;
        if (ld_r && checking) ld_q.push_back(model_load(ld_a));
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic apply_stimulus(input bit st_v, input logic [31:0] st_a, input logic [31:0] st_d,
                                  input bit ld_r, input logic [31:0] ld_a, input bit busy);
        drive_inputs(st_v, st_a, st_d, ld_r, ld_a, busy, 1'b0);
        tick();
    endtask

    task automatic idle(input int cycles, input bit busy);
        for (int i = 0; i < cycles; i++) apply_stimulus(1'b0, '0, '0, 1'b0, '0, busy);
    endtask

    // Monitor: pops expected loads and memory writes when the DUT presents them.
    always @(negedge clock) begin
        if (checking) begin
            if (sb_if.ld_req) begin
                if (ld_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL ld_queue: load seen with no expectation at %0t", $time);
                end else begin
                    load_t e;
                    e = ld_q.pop_front();
                    check_output("ld_hit", 32'(sb_if.ld_hit), 32'(e.hit));
                    check_output("ld_data", sb_if.ld_data, e.data);
                end
            end else begin
                check_output("ld_hit_idle", 32'(sb_if.ld_hit), 32'd0);
            end
            if (!sb_if._WR) begin
                tb_mem[sb_if.mem_addr] = sb_if.mem_wdata;
                if (wr_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL wr_queue: unexpected write addr 0x%08h at %0t", sb_if.mem_addr, $time);
                end else begin
                    word_t w;
                    w = wr_q.pop_front();
                    check_output("wr_addr", sb_if.mem_addr, w.addr);
                    check_output("wr_data", sb_if.mem_wdata, w.data);
                end
            end
            check_output("st_ready", 32'(sb_if.st_ready), 32'(model_pending.size() < DEPTH));
            check_output("_WR", 32'(sb_if._WR), 32'(!model_inflight_v));
            check_output("empty", 32'(sb_if.empty), 32'(model_pending.size() == 0 && !model_inflight_v));
            check_output("misalign", 32'(sb_if.misalign), 32'(model_misalign));
            check_output("mem_addr", sb_if.mem_addr, model_mem_addr);
            check_output("mem_wdata", sb_if.mem_wdata, model_mem_wdata);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        drive_inputs(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        tick();
        tick();
        checking = 1'b1;

        // Reset then idle
        idle(10, 1'b0);

        // Single store drains to memory the cycle after it is buffered
        apply_stimulus(1'b1, 32'h08, 32'h5, 1'b0, '0, 1'b0);
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
        drive_inputs(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        check_output("t2_wr_low", 32'(sb_if._WR), 32'd0);
        check_output("t2_mem_addr", sb_if.mem_addr, 32'h08);
        check_output("t2_mem_wdata", sb_if.mem_wdata, 32'h5);
        tick();
        drive_inputs(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        check_output("t2_empty", 32'(sb_if.empty), 32'd1);
        check_output("t2_mem_word8", tb_mem.exists(32'h08) ? tb_mem[32'h08] : 32'hDEAD_BEEF, 32'h5);
        tick();

        // Fill while memory is busy, drop the fifth store, then drain in order
        for (int i = 0; i < 4; i++)
            apply_stimulus(1'b1, 32'(i * 4), 32'h300 + 32'(i), 1'b0, '0, 1'b1);
        drive_inputs(1'b1, 32'h10, 32'h399, 1'b0, '0, 1'b1, 1'b0);
        check_output("t3_full", 32'(sb_if.st_ready), 32'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive_inputs(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
            if (k > 0) begin
                check_output("t3_wr_low", 32'(sb_if._WR), 32'd0);
                check_output("t3_order", sb_if.mem_addr, 32'((k - 1) * 4));
            end
            tick();
        end
        drive_inputs(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        check_output("t3_no_fifth", 32'(sb_if._WR), 32'd1);
        tick();

        // Youngest of two same-address stores is forwarded
        apply_stimulus(1'b1, 32'h10, 32'hAAAA_0001, 1'b0, '0, 1'b1);
        apply_stimulus(1'b1, 32'h10, 32'hBBBB_0002, 1'b0, '0, 1'b1);
        drive_inputs(1'b0, '0, '0, 1'b1, 32'h10, 1'b1, 1'b0);
        check_output("t4_hit", 32'(sb_if.ld_hit), 32'd1);
        check_output("t4_data", sb_if.ld_data, 32'hBBBB_0002);
        tick();
        drive_inputs(1'b0, '0, '0, 1'b1, 32'h14, 1'b1, 1'b0);
        check_output("t4_miss_hit", 32'(sb_if.ld_hit), 32'd0);
        check_output("t4_miss_data", sb_if.ld_data, 32'd0);
        tick();
        idle(4, 1'b0);

        // In-flight write is forwarded for exactly one cycle
        apply_stimulus(1'b1, 32'h20, 32'h55, 1'b0, '0, 1'b0);
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
        drive_inputs(1'b0, '0, '0, 1'b1, 32'h20, 1'b0, 1'b0);
        check_output("t5_inflight_hit", 32'(sb_if.ld_hit), 32'd1);
        check_output("t5_inflight_data", sb_if.ld_data, 32'h55);
        tick();
        drive_inputs(1'b0, '0, '0, 1'b1, 32'h20, 1'b0, 1'b0);
        check_output("t5_after_hit", 32'(sb_if.ld_hit), 32'd0);
        tick();

        // Random traffic over a small address window to exercise forwarding
        for (int i = 0; i < 300; i++) begin
            bit st_v, ld_r, busy;
            st_v = ($urandom_range(0, 1) == 1);
            ld_r = ($urandom_range(0, 1) == 1);
            busy = ($urandom_range(0, 9) < 4);
            apply_stimulus(st_v, 32'($urandom_range(0, 7)) << 2, $urandom,
                           ld_r, 32'($urandom_range(0, 7)) << 2, busy);
        end
        idle(8, 1'b0);

        // Misaligned load sets the sticky flag
        apply_stimulus(1'b0, '0, '0, 1'b1, 32'h21, 1'b0);
        drive_inputs(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        check_output("misalign_set", 32'(sb_if.misalign), 32'd1);
        tick();
        idle(3, 1'b0);

        // Push and drain on the same edge keep the count, then reset during a write
        for (int i = 0; i < 3; i++)
            apply_stimulus(1'b1, 32'h40 + 32'(i * 4), 32'h600 + 32'(i), 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive_inputs(1'b1, 32'h4C + 32'(i * 4), 32'h700 + 32'(i), 1'b0, '0, 1'b0, 1'b0);
            check_output("t6_ready_steady", 32'(sb_if.st_ready), 32'd1);
            tick();
        end
        apply_stimulus(1'b1, 32'h58, 32'h800, 1'b0, '0, 1'b1);
        drive_inputs(1'b1, 32'h5C, 32'h801, 1'b0, '0, 1'b1, 1'b0);
        check_output("t6_full", 32'(sb_if.st_ready), 32'd0);
        tick();
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
        drive_inputs(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        check_output("t6_reopen", 32'(sb_if.st_ready), 32'd1);
        check_output("t6_wr_before_reset", 32'(sb_if._WR), 32'd0);
        tick();
        drive_inputs(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        check_output("t6_wr_after_reset", 32'(sb_if._WR), 32'd1);
        check_output("t6_empty_after_reset", 32'(sb_if.empty), 32'd1);
        check_output("t6_misalign_cleared", 32'(sb_if.misalign), 32'd0);
        tick();
        idle(5, 1'b0);

        check_output("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        check_output("ld_queue_drained", 32'(ld_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
